// File: rtl/tick_bcd_counter_pkg.sv
// Shared types and helpers for the tick-driven BCD counter: FSM state
// encodings, digit width, and the start/stop transition function.
package tick_bcd_counter_pkg;

  // Width of one BCD digit.
  localparam int BCD_W = 4;

  // Sequencer states. 2'b11 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  // Next state for the start/stop sequencer. When start and stop are both
  // asserted, stop takes priority in every state.
  function automatic state_t fsm_next(input state_t cur,
                                      input logic   start,
                                      input logic   stop);
    state_t nxt;
    nxt = ST_IDLE;
    case (cur)
      ST_IDLE: nxt = (start && !stop) ? ST_RUN : ST_IDLE;
      ST_RUN:  nxt = stop ? ST_HOLD : ST_RUN;
      ST_HOLD: nxt = (start && !stop) ? ST_RUN : ST_HOLD;
      default: nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

  // Terminal value of a digit with the given modulus, in digit width.
  function automatic logic [BCD_W-1:0] bcd_last(input int unsigned modulus);
    return BCD_W'(modulus - 1);
  endfunction

endpackage

// File: rtl/tick_bcd_counter_if.sv
// Control and status bundle of the tick BCD counter. The master side
// (sequencer / bench) drives the tick and level controls; the slave side
// (the counter) returns the digits and status.
interface tick_bcd_counter_if;
  import tick_bcd_counter_pkg::*;

  logic             tick_in;
  logic             start;
  logic             stop;
  logic             clear;
  logic [BCD_W-1:0] ones;
  logic [BCD_W-1:0] tens;
  logic             running;
  logic             wrap_pulse;

  modport master (
    output tick_in, start, stop, clear,
    input  ones, tens, running, wrap_pulse
  );

  modport slave (
    input  tick_in, start, stop, clear,
    output ones, tens, running, wrap_pulse
  );

endinterface

// File: rtl/tick_bcd_counter_bcd_digit.sv
// One BCD digit with programmable modulus. Counts 0..MOD-1 directly in
// BCD, so no binary-to-BCD step is ever needed. carry flags the inc that
// rolls the digit from MOD-1 back to 0 and feeds the next digit up.
import tick_bcd_counter_pkg::*;

module bcd_digit #(
  parameter int unsigned MOD = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  localparam logic [BCD_W-1:0] LAST = bcd_last(MOD);

  logic at_last;

  assign at_last = (q == LAST);

  // Carry is combinational so the next digit steps in the same edge.
  assign carry = inc & at_last;

  // Digit register: clear beats increment, wrap at the terminal value.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      if (at_last) begin
        q <= '0;
      end else begin
        q <= q + BCD_W'(1);
      end
    end
  end

endmodule

// File: rtl/tick_bcd_counter.sv
// Tick BCD counter: edge-detects the divided square wave on tick_in and
// counts rising edges in two cascaded BCD digits while the start/stop
// sequencer is in RUN. A registered one-cycle wrap_pulse marks the
// terminal->0 roll so a further stage can be chained.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   ST_IDLE | after reset; tick edges dropped, waits for start
//   ST_RUN  | tick edges counted; running=1
//   ST_HOLD | paused by stop; tick edges dropped, start resumes
//   2'b11   | unused; returns to ST_IDLE next cycle
import tick_bcd_counter_pkg::*;

module tick_bcd_counter #(
  parameter int unsigned ONES_MOD = 10,
  parameter int unsigned TENS_MOD = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  tick_bcd_counter_if.slave     bus
);

  state_t           state_q;
  state_t           state_d;
  logic             tick_q;
  logic             tick_rise;
  logic             count_en;
  logic             ones_carry;
  logic             tens_carry;
  logic             wrap_q;
  logic [BCD_W-1:0] ones_q;
  logic [BCD_W-1:0] tens_q;

  // Previous tick level; reloads every cycle, so no re-sync after clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= bus.tick_in;
    end
  end

  assign tick_rise = bus.tick_in & ~tick_q;

  // Counting looks at the present state only: an edge together with stop
  // still counts, an edge together with start from HOLD/IDLE does not.
  assign count_en = (state_q == ST_RUN) & tick_rise & ~bus.clear;

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sequencer next-state logic; clear never affects the state.
  always_comb begin
    state_d = state_q;
    state_d = fsm_next(state_q, bus.start, bus.stop);
  end

  bcd_digit #(
    .MOD   (ONES_MOD)
  ) u_ones (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.clear),
    .inc   (count_en),
    .q     (ones_q),
    .carry (ones_carry)
  );

  bcd_digit #(
    .MOD   (TENS_MOD)
  ) u_tens (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.clear),
    .inc   (ones_carry),
    .q     (tens_q),
    .carry (tens_carry)
  );

  // Wrap flag: high for the one cycle after the terminal count rolls to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_q <= 1'b0;
    end else if (bus.clear) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= tens_carry;
    end
  end

  assign bus.ones       = ones_q;
  assign bus.tens       = tens_q;
  assign bus.running    = (state_q == ST_RUN);
  assign bus.wrap_pulse = wrap_q;

endmodule
